// File: rtl/wrapper_b2a_unit_if.sv
// ---------------------------------------------------------------------------
// wrapper_b2a_unit_if
// Bundle of request, randomness, operand and result signals for the masked
// B2A / masked add-sub unit. Clock and reset are kept outside the bundle.
//
// Handshake: the request fields (valid, op_*, rs*) are sampled only while the
// unit is idle; valid is taken on a rising edge with flush low and an enabled
// op_* high. There is no backpressure. ready is a one-cycle pulse that marks
// rd_s0/rd_s1 as the new result. The rs* inputs must be held from the start
// edge until ready. The z* words are consumed live every cycle.
//
// Signals:
//   flush, valid, op_add, op_sub, op_b2a   request controls (master -> slave)
//   z0..z7                                 fresh random words (z7 reserved)
//   rs1_s0/rs1_s1, rs2_s0/rs2_s1           Boolean operand shares
//   rd_s0/rd_s1                            result shares (slave -> master)
//   ready                                  result-valid pulse
//   dbg_state                              FSM state: 0 IDLE, 1 PREP, 2 PFX, 3 DONE
// ---------------------------------------------------------------------------
interface wrapper_b2a_unit_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 flush;
  logic                 valid;
  logic                 op_add;
  logic                 op_sub;
  logic                 op_b2a;
  logic [BIT_WIDTH-1:0] z0, z1, z2, z3, z4, z5, z6, z7;
  logic [BIT_WIDTH-1:0] rs1_s0, rs1_s1;
  logic [BIT_WIDTH-1:0] rs2_s0, rs2_s1;
  logic [BIT_WIDTH-1:0] rd_s0, rd_s1;
  logic                 ready;
  logic [1:0]           dbg_state;

  modport master (
    output flush, valid, op_add, op_sub, op_b2a,
    output z0, z1, z2, z3, z4, z5, z6, z7,
    output rs1_s0, rs1_s1, rs2_s0, rs2_s1,
    input  rd_s0, rd_s1, ready, dbg_state
  );

  modport slave (
    input  flush, valid, op_add, op_sub, op_b2a,
    input  z0, z1, z2, z3, z4, z5, z6, z7,
    input  rs1_s0, rs1_s1, rs2_s0, rs2_s1,
    output rd_s0, rd_s1, ready, dbg_state
  );
endinterface

// File: rtl/wrapper_b2a_unit.sv
// ---------------------------------------------------------------------------
// wrapper_b2a_unit
// First-order masked arithmetic unit. The main operation converts a Boolean
// sharing x = rs1_s0 ^ rs1_s1 into an arithmetic sharing with
// rd_s0 - rd_s1 = x (mod 2^BIT_WIDTH). It adds a random word r (z0) to x with
// a masked Kogge-Stone adder, then publishes (x + r, r).
//
// Optional feature macro: WRAPPER_B2A_ADDSUB_EN
//   defined   : op_add / op_sub compute Boolean shares of a + b / a - b.
//   undefined : only op_b2a starts an operation; rs2 and output z6 masking
//               are not built.
//
// Ports:
//   g_clk    rising-edge clock
//   g_reset  asynchronous active-high reset
//   bus      wrapper_b2a_unit_if.slave (request, randomness, operands,
//            result shares, ready pulse, debug state)
//
// Timing: start edge -> PREP -> PFX x log2(BIT_WIDTH) -> DONE; the result
// and ready are registered on the edge leaving DONE (7 edges after start for
// BIT_WIDTH = 32).
// ---------------------------------------------------------------------------
module wrapper_b2a_unit #(
  parameter int BIT_WIDTH = 32
) (
  input  logic              g_clk,
  input  logic              g_reset,
  wrapper_b2a_unit_if.slave bus
);

  localparam int LVLS = $clog2(BIT_WIDTH);
  localparam int LW   = $clog2(LVLS + 1);
  localparam logic [LW-1:0] LAST_LVL = LW'(LVLS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_PFX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [LW-1:0]        r_lvl;
  logic [BIT_WIDTH-1:0] r_a0, r_a1;
  logic [BIT_WIDTH-1:0] r_mask;
  logic [BIT_WIDTH-1:0] r_p0, r_p1;   // bitwise propagate shares, kept for the sum
  logic [BIT_WIDTH-1:0] r_g0, r_g1;   // group generate shares
  logic [BIT_WIDTH-1:0] r_q0, r_q1;   // group propagate shares
  logic [BIT_WIDTH-1:0] r_rd_s0, r_rd_s1;
  logic                 r_ready;
`ifdef WRAPPER_B2A_ADDSUB_EN
  logic                 r_is_b2a;
  logic                 r_is_sub;
  logic [BIT_WIDTH-1:0] r_b0, r_b1;
`endif

  logic                 w_any_op;
  logic                 w_start;
  logic                 w_cin;
  logic [BIT_WIDTH-1:0] w_b0, w_b1;
  logic [BIT_WIDTH-1:0] w_p0, w_p1;
  logic [BIT_WIDTH-1:0] w_gd0, w_gd1;
  logic [BIT_WIDTH-1:0] w_g0, w_g1;
  logic [31:0]          w_sh, w_span, w_zidx, w_rot;
  logic [BIT_WIDTH-1:0] w_zsel, w_zr;
  logic [BIT_WIDTH-1:0] w_t0, w_t1;
  logic [BIT_WIDTH-1:0] w_gn0, w_gn1;
  logic [BIT_WIDTH-1:0] w_qn0, w_qn1;
  logic [BIT_WIDTH-1:0] w_s0, w_s1;

  // DOM-style masked AND: shares of (x0^x1) & (y0^y1); the cross terms are
  // refreshed by z before being folded into each share.
  function automatic logic [2*BIT_WIDTH-1:0] dom_and(
    input logic [BIT_WIDTH-1:0] x0, x1, y0, y1, z
  );
    logic [BIT_WIDTH-1:0] q0, q1;
    q0 = (x0 & y0) ^ ((x0 & y1) ^ z);
    q1 = (x1 & y1) ^ ((x1 & y0) ^ z);
    return {q0, q1};
  endfunction

`ifdef WRAPPER_B2A_ADDSUB_EN
  assign w_any_op = bus.op_b2a | bus.op_sub | bus.op_add;
  assign w_cin    = r_is_sub;
`else
  assign w_any_op = bus.op_b2a;
  assign w_cin    = 1'b0;
  logic w_unused_ops;
  assign w_unused_ops = ^{bus.op_add, bus.op_sub, bus.rs2_s0, bus.rs2_s1};
`endif
  assign w_start = bus.valid & ~bus.flush & w_any_op;

  // z7 is reserved; it is deliberately never used.
  logic w_unused_z7;
  assign w_unused_z7 = ^bus.z7;

  // PREP: operand B, propagate (linear) and generate (masked AND, z1).
  always_comb begin
`ifdef WRAPPER_B2A_ADDSUB_EN
    w_b0 = r_is_b2a ? bus.z0 : (r_is_sub ? ~r_b0 : r_b0);
    w_b1 = r_is_b2a ? '0 : r_b1;
`else
    w_b0 = bus.z0;
    w_b1 = '0;
`endif
    w_p0 = r_a0 ^ w_b0;
    w_p1 = r_a1 ^ w_b1;
    {w_gd0, w_gd1} = dom_and(r_a0, r_a1, w_b0, w_b1, bus.z1);
    // Carry-in folds into bit 0 as g ^= p (g and p are mutually exclusive),
    // applied to both shares so it stays linear.
    w_g0 = w_gd0 ^ {{(BIT_WIDTH-1){1'b0}}, w_cin & w_p0[0]};
    w_g1 = w_gd1 ^ {{(BIT_WIDTH-1){1'b0}}, w_cin & w_p1[0]};
  end

  // PFX level k = r_lvl: span 2^(k-1), refresh z(k+1) rotated left by k.
  // Group G and P at the same position are disjoint, so the OR of the
  // prefix operator can be an XOR of shares.
  always_comb begin
    w_sh   = 32'(r_lvl) - 32'd1;
    w_span = 32'd1 << w_sh;
    w_zidx = ((32'(r_lvl) + 32'd4) % 32'd5) + 32'd2;
    case (w_zidx)
      32'd2:   w_zsel = bus.z2;
      32'd3:   w_zsel = bus.z3;
      32'd4:   w_zsel = bus.z4;
      32'd5:   w_zsel = bus.z5;
      default: w_zsel = bus.z6;
    endcase
    w_rot = 32'(BIT_WIDTH) - 32'(r_lvl);
    w_zr  = (w_zsel << r_lvl) | (w_zsel >> w_rot);
    {w_t0, w_t1}   = dom_and(r_q0, r_q1, r_g0 << w_span, r_g1 << w_span, w_zr);
    w_gn0 = r_g0 ^ w_t0;
    w_gn1 = r_g1 ^ w_t1;
    {w_qn0, w_qn1} = dom_and(r_q0, r_q1, r_q0 << w_span, r_q1 << w_span, w_zr);
  end

  // Sum shares: the carry into bit i+1 is group generate [i:0]; carry-in
  // enters bit 0 on share 0 only.
  assign w_s0 = r_p0 ^ {r_g0[BIT_WIDTH-2:0], w_cin};
  assign w_s1 = r_p1 ^ {r_g1[BIT_WIDTH-2:0], 1'b0};

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state <= S_IDLE;
      r_lvl   <= '0;
      r_a0    <= '0;
      r_a1    <= '0;
      r_mask  <= '0;
      r_p0    <= '0;
      r_p1    <= '0;
      r_g0    <= '0;
      r_g1    <= '0;
      r_q0    <= '0;
      r_q1    <= '0;
      r_rd_s0 <= '0;
      r_rd_s1 <= '0;
      r_ready <= 1'b0;
`ifdef WRAPPER_B2A_ADDSUB_EN
      r_is_b2a <= 1'b0;
      r_is_sub <= 1'b0;
      r_b0     <= '0;
      r_b1     <= '0;
`endif
    end else begin
      r_ready <= 1'b0;
      if (bus.flush) begin
        // Abort wins over start and over DONE; rd keeps its last value.
        r_state <= S_IDLE;
        r_lvl   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_a0 <= bus.rs1_s0;
              r_a1 <= bus.rs1_s1;
`ifdef WRAPPER_B2A_ADDSUB_EN
              r_b0     <= bus.rs2_s0;
              r_b1     <= bus.rs2_s1;
              r_is_b2a <= bus.op_b2a;
              r_is_sub <= ~bus.op_b2a & bus.op_sub;
`endif
              r_state <= S_PREP;
            end
          end
          S_PREP: begin
            r_p0    <= w_p0;
            r_p1    <= w_p1;
            r_g0    <= w_g0;
            r_g1    <= w_g1;
            r_q0    <= w_p0;
            r_q1    <= w_p1;
            r_mask  <= bus.z0;
            r_lvl   <= LW'(1);
            r_state <= S_PFX;
          end
          S_PFX: begin
            r_g0 <= w_gn0;
            r_g1 <= w_gn1;
            r_q0 <= w_qn0;
            r_q1 <= w_qn1;
            if (r_lvl == LAST_LVL) begin
              r_lvl   <= '0;
              r_state <= S_DONE;
            end else begin
              r_lvl <= r_lvl + LW'(1);
            end
          end
          S_DONE: begin
`ifdef WRAPPER_B2A_ADDSUB_EN
            if (r_is_b2a) begin
              r_rd_s0 <= w_s0 ^ w_s1;
              r_rd_s1 <= r_mask;
            end else begin
              r_rd_s0 <= w_s0 ^ bus.z6;
              r_rd_s1 <= w_s1 ^ bus.z6;
            end
`else
            // x + r is masked by r, so it may be recombined.
            r_rd_s0 <= w_s0 ^ w_s1;
            r_rd_s1 <= r_mask;
`endif
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rd_s0     = r_rd_s0;
  assign bus.rd_s1     = r_rd_s1;
  assign bus.ready     = r_ready;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_wrapper_b2a_unit.sv
// ---------------------------------------------------------------------------
// tb_wrapper_b2a_unit
// Self-checking bench for wrapper_b2a_unit (BIT_WIDTH = 32). Expected results
// come from plain modular arithmetic on the recombined shares.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wrapper_b2a_unit;

  localparam int W       = 32;
  // ready appears 7 edges after the start edge, i.e. on the 8th falling edge
  // after the request is driven at a falling edge.
  localparam int LAT_NEG = 8;
  localparam int TIMEOUT = 20;
  localparam int N_RAND  = 2000;

  logic g_clk;
  logic g_reset;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rd0, exp_rd1;

  wrapper_b2a_unit_if #(.BIT_WIDTH(W)) bus ();

  wrapper_b2a_unit #(.BIT_WIDTH(W)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog: got no end of run expected end before 5ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.flush  = 1'b0;
    bus.valid  = 1'b0;
    bus.op_add = 1'b0;
    bus.op_sub = 1'b0;
    bus.op_b2a = 1'b0;
    bus.z0 = '0; bus.z1 = '0; bus.z2 = '0; bus.z3 = '0;
    bus.z4 = '0; bus.z5 = '0; bus.z6 = '0; bus.z7 = '0;
    bus.rs1_s0 = '0; bus.rs1_s1 = '0;
    bus.rs2_s0 = '0; bus.rs2_s1 = '0;
  endtask

  task automatic rand_z(input bit hold_z0);
    if (!hold_z0) bus.z0 = $urandom;
    bus.z1 = $urandom; bus.z2 = $urandom; bus.z3 = $urandom;
    bus.z4 = $urandom; bus.z5 = $urandom; bus.z6 = $urandom;
    bus.z7 = $urandom;
  endtask

  // Raise valid at a falling edge and wait for ready (bounded).
  task automatic run_op(input bit keep_valid, input bit hold_z0,
                        output int lat, output logic first_rdy);
    bit got;
    bus.valid = 1'b1;
    lat       = 0;
    first_rdy = 1'b0;
    got       = 1'b0;
    while (!got && lat < TIMEOUT) begin
      @(negedge g_clk);
      lat++;
      if (lat == 1) begin
        first_rdy = bus.ready;
        if (!keep_valid) bus.valid = 1'b0;
      end else if (bus.ready === 1'b1) begin
        got = 1'b1;
      end
      if (!got) rand_z(hold_z0);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    g_reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge g_clk);
    checks++; if (bus.rd_s0 !== '0) begin errors++; $display("FAIL reset_rd_s0: got %h expected 0", bus.rd_s0); end
    checks++; if (bus.rd_s1 !== '0) begin errors++; $display("FAIL reset_rd_s1: got %h expected 0", bus.rd_s1); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    checks++; if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.dbg_state); end
    g_reset = 1'b0;
    @(negedge g_clk);
  endtask

  task automatic test_b2a_directed();
    int lat;
    logic fr;
    logic [W-1:0] diff;
    bus.op_b2a = 1'b1;
    bus.rs1_s0 = 32'h0484D609;
    bus.rs1_s1 = 32'h31F05663;
    bus.z0     = 32'hae366011;
    rand_z(1'b1);
    run_op(1'b0, 1'b1, lat, fr);
    diff = bus.rd_s0 - bus.rd_s1;
    checks++; if (lat !== LAT_NEG) begin errors++; $display("FAIL b2a_latency: got %0d expected %0d", lat, LAT_NEG); end
    checks++; if (diff !== 32'h3574806A) begin errors++; $display("FAIL b2a_diff: got %h expected 3574806a", diff); end
    checks++; if (bus.rd_s1 !== 32'hae366011) begin errors++; $display("FAIL b2a_rd_s1: got %h expected ae366011", bus.rd_s1); end
    @(negedge g_clk);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL b2a_ready_width: got %b expected 0", bus.ready); end
  endtask

  task automatic test_wrap();
    int lat;
    logic fr;
    bus.op_b2a = 1'b1;
    bus.rs1_s0 = 32'hFFFFFFFF;
    bus.rs1_s1 = 32'h0;
    bus.z0     = 32'h1;
    run_op(1'b0, 1'b1, lat, fr);
    exp_rd0 = 32'hFFFFFFFF + 32'h1;
    exp_rd1 = 32'h1;
    checks++; if (lat !== LAT_NEG) begin errors++; $display("FAIL wrap_latency: got %0d expected %0d", lat, LAT_NEG); end
    checks++; if (bus.rd_s0 !== exp_rd0) begin errors++; $display("FAIL wrap_rd_s0: got %h expected %h", bus.rd_s0, exp_rd0); end
    checks++; if (bus.rd_s1 !== exp_rd1) begin errors++; $display("FAIL wrap_rd_s1: got %h expected %h", bus.rd_s1, exp_rd1); end
    @(negedge g_clk);
  endtask

  task automatic test_flush();
    int lat, seen;
    logic fr;
    logic [W-1:0] x, r, diff;
    bus.op_b2a = 1'b1;
    bus.rs1_s0 = $urandom;
    bus.rs1_s1 = $urandom;
    bus.valid  = 1'b1;
    // Falling edges 1..4 fall in PREP, PFX1, PFX2, PFX3.
    for (int i = 1; i <= 4; i++) begin
      @(negedge g_clk);
      bus.valid = 1'b0;
      rand_z(1'b0);
    end
    bus.flush = 1'b1;
    @(negedge g_clk);
    bus.flush = 1'b0;
    checks++; if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL flush_idle: got %0d expected 0", bus.dbg_state); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", bus.ready); end
    checks++; if (bus.rd_s0 !== exp_rd0 || bus.rd_s1 !== exp_rd1) begin
      errors++; $display("FAIL flush_rd_held: got %h/%h expected %h/%h", bus.rd_s0, bus.rd_s1, exp_rd0, exp_rd1);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge g_clk);
      if (bus.ready === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_ready: got %0d pulses expected 0", seen); end
    // Next operation after the abort.
    r = $urandom;
    bus.rs1_s0 = $urandom;
    bus.rs1_s1 = $urandom;
    bus.z0     = r;
    x = bus.rs1_s0 ^ bus.rs1_s1;
    run_op(1'b0, 1'b1, lat, fr);
    diff = bus.rd_s0 - bus.rd_s1;
    checks++; if (lat !== LAT_NEG) begin errors++; $display("FAIL flush_next_latency: got %0d expected %0d", lat, LAT_NEG); end
    checks++; if (diff !== x) begin errors++; $display("FAIL flush_next_diff: got %h expected %h", diff, x); end
    checks++; if (bus.rd_s1 !== r) begin errors++; $display("FAIL flush_next_rd_s1: got %h expected %h", bus.rd_s1, r); end
    @(negedge g_clk);
  endtask

  task automatic test_back_to_back(input int n);
    int lat;
    logic fr;
    logic [W-1:0] diff, exp;
    bus.op_b2a = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.rs1_s0 = $urandom;
      bus.rs1_s1 = $urandom;
      exp_q.push_back(bus.rs1_s0 ^ bus.rs1_s1);
      run_op(1'b1, 1'b0, lat, fr);
      exp  = exp_q.pop_front();
      diff = bus.rd_s0 - bus.rd_s1;
      checks++; if (lat !== LAT_NEG) begin errors++; $display("FAIL b2b_latency op %0d: got %0d expected %0d", i, lat, LAT_NEG); end
      if (i > 0) begin
        checks++; if (fr !== 1'b0) begin errors++; $display("FAIL b2b_ready_width op %0d: got %b expected 0", i, fr); end
      end
      checks++; if ($isunknown({bus.rd_s0, bus.rd_s1})) begin errors++; $display("FAIL b2b_rd_x op %0d: got %h/%h expected no X", i, bus.rd_s0, bus.rd_s1); end
      checks++; if (diff !== exp) begin errors++; $display("FAIL b2b_diff op %0d: got %h expected %h", i, diff, exp); end
    end
    bus.valid = 1'b0;
    @(negedge g_clk);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_last_ready_width: got %b expected 0", bus.ready); end
  endtask

`ifdef WRAPPER_B2A_ADDSUB_EN
  task automatic test_addsub();
    int lat;
    logic fr, sub;
    logic [W-1:0] a, b, m, res, exp, diff;
    // Directed: 5 - 7 wraps to 0xFFFFFFFE.
    bus.op_b2a = 1'b0;
    bus.op_add = 1'b0;
    bus.op_sub = 1'b1;
    m = $urandom; bus.rs1_s0 = m; bus.rs1_s1 = m ^ 32'd5;
    m = $urandom; bus.rs2_s0 = m; bus.rs2_s1 = m ^ 32'd7;
    run_op(1'b0, 1'b0, lat, fr);
    res = bus.rd_s0 ^ bus.rd_s1;
    checks++; if (lat !== LAT_NEG) begin errors++; $display("FAIL sub_latency: got %0d expected %0d", lat, LAT_NEG); end
    checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_5_7: got %h expected fffffffe", res); end
    @(negedge g_clk);
    // Random add / sub; both op bits set must behave as sub.
    for (int i = 0; i < 40; i++) begin
      sub = $urandom_range(0, 1);
      bus.op_sub = sub;
      bus.op_add = (!sub) | ($urandom_range(0, 1) == 1);
      bus.rs1_s0 = $urandom; bus.rs1_s1 = $urandom;
      bus.rs2_s0 = $urandom; bus.rs2_s1 = $urandom;
      a = bus.rs1_s0 ^ bus.rs1_s1;
      b = bus.rs2_s0 ^ bus.rs2_s1;
      exp = sub ? (a - b) : (a + b);
      run_op(1'b0, 1'b0, lat, fr);
      res = bus.rd_s0 ^ bus.rd_s1;
      checks++; if (res !== exp) begin errors++; $display("FAIL addsub op %0d sub=%0b: got %h expected %h", i, sub, res, exp); end
      @(negedge g_clk);
    end
    // B2A wins over sub.
    bus.op_b2a = 1'b1;
    bus.op_sub = 1'b1;
    bus.op_add = 1'b0;
    bus.rs1_s0 = $urandom; bus.rs1_s1 = $urandom;
    a = bus.rs1_s0 ^ bus.rs1_s1;
    run_op(1'b0, 1'b0, lat, fr);
    diff = bus.rd_s0 - bus.rd_s1;
    checks++; if (diff !== a) begin errors++; $display("FAIL prio_b2a: got %h expected %h", diff, a); end
    bus.op_sub = 1'b0;
    @(negedge g_clk);
  endtask
`else
  task automatic test_ops_ignored();
    int seen, busy;
    bus.op_b2a = 1'b0;
    bus.op_add = 1'b1;
    bus.op_sub = 1'b1;
    bus.valid  = 1'b1;
    seen = 0;
    busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge g_clk);
      rand_z(1'b0);
      if (bus.ready === 1'b1) seen++;
      if (bus.dbg_state !== 2'd0) busy++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL ignored_ready: got %0d pulses expected 0", seen); end
    checks++; if (busy !== 0) begin errors++; $display("FAIL ignored_started: got %0d busy cycles expected 0", busy); end
    bus.valid  = 1'b0;
    bus.op_add = 1'b0;
    bus.op_sub = 1'b0;
    @(negedge g_clk);
  endtask
`endif

  task automatic test_reset_mid();
    int lat;
    logic fr;
    logic [W-1:0] x, diff;
    bus.op_b2a = 1'b1;
    bus.rs1_s0 = $urandom;
    bus.rs1_s1 = $urandom;
    bus.valid  = 1'b1;
    repeat (3) begin
      @(negedge g_clk);
      bus.valid = 1'b0;
      rand_z(1'b0);
    end
    #2 g_reset = 1'b1;
    #1;
    checks++; if (bus.rd_s0 !== '0 || bus.rd_s1 !== '0) begin
      errors++; $display("FAIL midreset_rd: got %h/%h expected 0/0", bus.rd_s0, bus.rd_s1);
    end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b expected 0", bus.ready); end
    checks++; if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d expected 0", bus.dbg_state); end
    @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);
    bus.rs1_s0 = $urandom;
    bus.rs1_s1 = $urandom;
    x = bus.rs1_s0 ^ bus.rs1_s1;
    run_op(1'b0, 1'b0, lat, fr);
    diff = bus.rd_s0 - bus.rd_s1;
    checks++; if (diff !== x) begin errors++; $display("FAIL midreset_next_diff: got %h expected %h", diff, x); end
    @(negedge g_clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    exp_rd0 = '0;
    exp_rd1 = '0;
    test_reset();
    test_b2a_directed();
    test_wrap();
    test_flush();
    test_back_to_back(N_RAND);
`ifdef WRAPPER_B2A_ADDSUB_EN
    test_addsub();
`else
    test_ops_ignored();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
